// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the PC sequencer
//
// Purpose: holds the context state encoding, the PC width and the default
// BIOS entry address. The top level, its interface and pc_next_calc all use it.
// Ports: none (package).

package pc_sequencer_pkg;

    localparam int PC_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] BIOS_ENTRY_DEFAULT = 32'd0;

    typedef enum logic [1:0] {
        BIOS_RUN = 2'd0,
        TO_PROC  = 2'd1,
        PROC_RUN = 2'd2,
        TO_BIOS  = 2'd3
    } seq_state_t;

    // True when the fetch address must come from the process PC register.
    function automatic logic is_proc_context(input seq_state_t s);
        return (s == TO_PROC) || (s == PROC_RUN);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between the core and the PC sequencer
//
// Purpose: groups the handshake and PC buses of pc_sequencer.
// Ports: none. The master modport is the side driving control (BIOS/core);
// the slave modport is the sequencer itself.
// Optional feature: PC_SEQ_SWITCH_COUNT_EN adds the 16-bit switch_count.

interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic                controll;
    logic                write_process_pc;
    logic [PC_WIDTH-1:0] new_pc_value;
    logic                done_inst;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] pc;
    logic                exec_mode;
    logic [PC_WIDTH-1:0] saved_pc;
    logic                switch_busy;
`ifdef PC_SEQ_SWITCH_COUNT_EN
    logic [15:0]         switch_count;
`endif

    modport master (
        output controll, write_process_pc, new_pc_value,
        output done_inst, branch_taken, branch_target,
        input  pc, exec_mode, saved_pc, switch_busy
`ifdef PC_SEQ_SWITCH_COUNT_EN
        , input switch_count
`endif
    );

    modport slave (
        input  controll, write_process_pc, new_pc_value,
        input  done_inst, branch_taken, branch_target,
        output pc, exec_mode, saved_pc, switch_busy
`ifdef PC_SEQ_SWITCH_COUNT_EN
        , output switch_count
`endif
    );

endinterface

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - next-PC select: branch target or sequential increment
//
// Purpose: combinational next-PC for one context register.
// Ports:
//   cur_pc        - current PC of the context
//   branch_taken  - retiring instruction redirects
//   branch_target - redirect address
//   next_pc       - branch_target if taken, else cur_pc+1 (wraps modulo 2^32)

module pc_next_calc
    import pc_sequencer_pkg::*;
(
    input  logic [PC_WIDTH-1:0] cur_pc,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] next_pc
);

    assign next_pc = branch_taken ? branch_target : cur_pc + PC_WIDTH'(1);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - BIOS/process context PC sequencer with preemption
//
// Purpose: keeps separate BIOS and process PCs, switches between them at
// instruction boundaries through one-cycle transition states, and saves the
// process PC on preemption.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - pc_sequencer_if.slave: controll, write_process_pc, new_pc_value,
//          done_inst, branch_taken, branch_target in; pc, exec_mode,
//          saved_pc, switch_busy (and switch_count) out, all registered
// Parameter: BIOS_ENTRY - BIOS restart address
// Optional feature: PC_SEQ_SWITCH_COUNT_EN adds a 16-bit wrapping count of
// entries into TO_BIOS.

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] BIOS_ENTRY = BIOS_ENTRY_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    seq_state_t          state, state_nx;
    logic [PC_WIDTH-1:0] bios_pc, process_pc;
    logic [PC_WIDTH-1:0] bios_pc_nx, proc_pc_nx;
    logic [PC_WIDTH-1:0] bios_pc_adv, proc_pc_adv;
    logic [PC_WIDTH-1:0] saved_pc_q, pc_q;
    logic                exec_mode_q, switch_busy_q;

    pc_next_calc u_bios_next (
        .cur_pc        (bios_pc),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .next_pc       (bios_pc_adv)
    );

    pc_next_calc u_proc_next (
        .cur_pc        (process_pc),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .next_pc       (proc_pc_adv)
    );

    always_comb begin
        state_nx   = state;
        bios_pc_nx = bios_pc;
        proc_pc_nx = process_pc;
        case (state)
            BIOS_RUN: begin
                // A load in the launching cycle is what TO_PROC fetches from.
                if (bus.write_process_pc) proc_pc_nx = bus.new_pc_value;
                if (bus.done_inst) begin
                    bios_pc_nx = bios_pc_adv;
                    if (!bus.controll) state_nx = TO_PROC;
                end
            end
            TO_PROC: state_nx = PROC_RUN;
            PROC_RUN: begin
                // Preemption waits for the retiring instruction.
                if (bus.done_inst) begin
                    proc_pc_nx = proc_pc_adv;
                    if (bus.controll) state_nx = TO_BIOS;
                end
            end
            TO_BIOS: begin
                bios_pc_nx = BIOS_ENTRY;
                state_nx   = BIOS_RUN;
            end
            default: state_nx = BIOS_RUN;
        endcase
    end

    // Outputs are computed from next-state values so that the registered pc
    // always matches the register selected by the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BIOS_RUN;
            bios_pc       <= BIOS_ENTRY;
            process_pc    <= '0;
            saved_pc_q    <= '0;
            pc_q          <= BIOS_ENTRY;
            exec_mode_q   <= 1'b0;
            switch_busy_q <= 1'b0;
        end else begin
            state         <= state_nx;
            bios_pc       <= bios_pc_nx;
            process_pc    <= proc_pc_nx;
            if (state == TO_BIOS) saved_pc_q <= process_pc;
            pc_q          <= is_proc_context(state_nx) ? proc_pc_nx : bios_pc_nx;
            exec_mode_q   <= is_proc_context(state_nx);
            switch_busy_q <= (state_nx == TO_PROC) || (state_nx == TO_BIOS);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.exec_mode   = exec_mode_q;
    assign bus.saved_pc    = saved_pc_q;
    assign bus.switch_busy = switch_busy_q;

`ifdef PC_SEQ_SWITCH_COUNT_EN
    logic [15:0] switch_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            switch_count_q <= '0;
        end else if (state == PROC_RUN && state_nx == TO_BIOS) begin
            switch_count_q <= switch_count_q + 16'd1;
        end
    end

    assign bus.switch_count = switch_count_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: which context owns the core and whether a handover
    // is in progress, plus the architectural PC values.
    bit          m_in_proc;
    bit          m_in_switch;
    logic [31:0] m_bios, m_proc, m_saved;
    logic [15:0] m_cnt;

    function automatic logic [31:0] exp_pc();
        return m_in_proc ? m_proc : m_bios;
    endfunction

    task automatic step(input bit r, input bit c, input bit w, input logic [31:0] nv,
                        input bit d, input bit bt, input logic [31:0] tg);
        rst                  = r;
        bus.controll         = c;
        bus.write_process_pc = w;
        bus.new_pc_value     = nv;
        bus.done_inst        = d;
        bus.branch_taken     = bt;
        bus.branch_target    = tg;
        @(posedge clk);
        if (r) begin
            m_in_proc = 0; m_in_switch = 0;
            m_bios = BIOS_ENTRY_DEFAULT; m_proc = 0; m_saved = 0; m_cnt = 0;
        end else if (m_in_switch) begin
            if (!m_in_proc) begin
                m_saved = m_proc;
                m_bios  = BIOS_ENTRY_DEFAULT;
            end
            m_in_switch = 0;
        end else if (!m_in_proc) begin
            if (w) m_proc = nv;
            if (d) begin
                m_bios = bt ? tg : m_bios + 32'd1;
                if (!c) begin m_in_proc = 1; m_in_switch = 1; end
            end
        end else if (d) begin
            m_proc = bt ? tg : m_proc + 32'd1;
            if (c) begin m_in_proc = 0; m_in_switch = 1; m_cnt = m_cnt + 16'd1; end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit c);
        step(0, c, 0, 32'd0, 0, 0, 32'd0);
    endtask

    task automatic test_reset();
        step(1, 1, 0, 32'd0, 0, 0, 32'd0);
        step(1, 1, 1, 32'h55, 1, 1, 32'h99);
        n_checks++; if (bus.pc !== 32'd0) begin n_fails++; $display("FAIL reset_pc actual=%h required=%h", bus.pc, 32'd0); end
        n_checks++; if (bus.exec_mode !== 1'b0) begin n_fails++; $display("FAIL reset_exec actual=%b required=0", bus.exec_mode); end
        n_checks++; if (bus.switch_busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy actual=%b required=0", bus.switch_busy); end
        n_checks++; if (bus.saved_pc !== 32'd0) begin n_fails++; $display("FAIL reset_saved actual=%h required=0", bus.saved_pc); end
`ifdef PC_SEQ_SWITCH_COUNT_EN
        n_checks++; if (bus.switch_count !== 16'd0) begin n_fails++; $display("FAIL reset_count actual=%h required=0", bus.switch_count); end
`endif
    endtask

    task automatic test_bios_count();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'd0, 1, 0, 32'd0);
            idle(1);
        end
        n_checks++; if (bus.pc !== 32'd3) begin n_fails++; $display("FAIL bios_count_pc actual=%h required=%h", bus.pc, 32'd3); end
        n_checks++; if (bus.exec_mode !== 1'b0) begin n_fails++; $display("FAIL bios_count_exec actual=%b required=0", bus.exec_mode); end
        // Giving up control without a retiring instruction must not launch.
        idle(0);
        n_checks++; if (bus.exec_mode !== 1'b0 || bus.switch_busy !== 1'b0) begin n_fails++; $display("FAIL bios_hold actual=%b%b required=00", bus.exec_mode, bus.switch_busy); end
    endtask

    task automatic test_launch();
        step(0, 1, 1, 32'h40, 0, 0, 32'd0);
        step(0, 0, 0, 32'd0, 1, 0, 32'd0);
        n_checks++; if (bus.switch_busy !== 1'b1) begin n_fails++; $display("FAIL to_proc_busy actual=%b required=1", bus.switch_busy); end
        n_checks++; if (bus.pc !== 32'h40) begin n_fails++; $display("FAIL to_proc_pc actual=%h required=%h", bus.pc, 32'h40); end
        // Retire/branch inputs during the handover are ignored.
        step(0, 0, 0, 32'd0, 1, 1, 32'h777);
        n_checks++; if (bus.pc !== 32'h40 || bus.exec_mode !== 1'b1 || bus.switch_busy !== 1'b0) begin
            n_fails++; $display("FAIL proc_run_entry actual=%h/%b/%b required=00000040/1/0", bus.pc, bus.exec_mode, bus.switch_busy);
        end
    endtask

    task automatic test_preempt();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'd0, 1, 0, 32'd0);
        n_checks++; if (bus.pc !== 32'h45) begin n_fails++; $display("FAIL proc_advance actual=%h required=%h", bus.pc, 32'h45); end
        // Write is ignored outside BIOS_RUN; controll alone does not preempt.
        step(0, 1, 1, 32'h1234, 0, 0, 32'd0);
        idle(1);
        n_checks++; if (bus.pc !== 32'h45 || bus.exec_mode !== 1'b1) begin n_fails++; $display("FAIL preempt_hold actual=%h/%b required=00000045/1", bus.pc, bus.exec_mode); end
        step(0, 1, 0, 32'd0, 1, 0, 32'd0);
        n_checks++; if (bus.switch_busy !== 1'b1 || bus.exec_mode !== 1'b0 || bus.pc !== exp_pc()) begin
            n_fails++; $display("FAIL to_bios actual=%h/%b/%b required=%h/0/1", bus.pc, bus.exec_mode, bus.switch_busy, exp_pc());
        end
        idle(1);
        n_checks++; if (bus.saved_pc !== 32'h46) begin n_fails++; $display("FAIL saved_pc actual=%h required=%h", bus.saved_pc, 32'h46); end
        n_checks++; if (bus.pc !== 32'd0 || bus.exec_mode !== 1'b0) begin n_fails++; $display("FAIL bios_reentry actual=%h/%b required=00000000/0", bus.pc, bus.exec_mode); end
    endtask

    task automatic test_branch_wrap();
        // Load and launch in the same cycle: TO_PROC fetches the new value.
        step(0, 0, 1, 32'h200, 1, 0, 32'd0);
        n_checks++; if (bus.pc !== 32'h200) begin n_fails++; $display("FAIL same_cycle_load actual=%h required=%h", bus.pc, 32'h200); end
        idle(0);
        step(0, 0, 0, 32'd0, 1, 1, 32'h100);
        n_checks++; if (bus.pc !== 32'h100) begin n_fails++; $display("FAIL proc_branch actual=%h required=%h", bus.pc, 32'h100); end
        step(0, 1, 0, 32'd0, 1, 0, 32'd0);
        idle(1);
        step(0, 0, 1, 32'hFFFF_FFFF, 1, 0, 32'd0);
        idle(0);
        n_checks++; if (bus.pc !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL wrap_start actual=%h required=ffffffff", bus.pc); end
        step(0, 0, 0, 32'd0, 1, 0, 32'd0);
        n_checks++; if (bus.pc !== 32'd0) begin n_fails++; $display("FAIL wrap actual=%h required=0", bus.pc); end
    endtask

    task automatic test_reset_in_to_bios();
        step(0, 1, 0, 32'd0, 1, 0, 32'd0);
        n_checks++; if (bus.switch_busy !== 1'b1) begin n_fails++; $display("FAIL pre_rst_busy actual=%b required=1", bus.switch_busy); end
        step(1, 1, 0, 32'd0, 0, 0, 32'd0);
        n_checks++; if (bus.pc !== 32'd0 || bus.saved_pc !== 32'd0 || bus.exec_mode !== 1'b0 || bus.switch_busy !== 1'b0) begin
            n_fails++; $display("FAIL rst_to_bios actual=%h/%h/%b/%b required=0/0/0/0", bus.pc, bus.saved_pc, bus.exec_mode, bus.switch_busy);
        end
        // Reset during TO_PROC as well.
        step(0, 0, 1, 32'h80, 1, 0, 32'd0);
        step(1, 0, 0, 32'd0, 0, 0, 32'd0);
        n_checks++; if (bus.pc !== 32'd0 || bus.exec_mode !== 1'b0 || bus.switch_busy !== 1'b0) begin
            n_fails++; $display("FAIL rst_to_proc actual=%h/%b/%b required=0/0/0", bus.pc, bus.exec_mode, bus.switch_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2) : $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0), $urandom);
            n_checks++;
            if (bus.pc !== exp_pc() || bus.exec_mode !== m_in_proc || bus.switch_busy !== m_in_switch || bus.saved_pc !== m_saved) begin
                n_fails++;
                $display("FAIL random cyc=%0d actual pc=%h ex=%b busy=%b saved=%h required pc=%h ex=%b busy=%b saved=%h",
                         i, bus.pc, bus.exec_mode, bus.switch_busy, bus.saved_pc, exp_pc(), m_in_proc, m_in_switch, m_saved);
            end
`ifdef PC_SEQ_SWITCH_COUNT_EN
            n_checks++;
            if (bus.switch_count !== m_cnt) begin n_fails++; $display("FAIL random_count cyc=%0d actual=%h required=%h", i, bus.switch_count, m_cnt); end
`endif
        end
    endtask

`ifdef PC_SEQ_SWITCH_COUNT_EN
    task automatic test_switch_count();
        step(1, 1, 0, 32'd0, 0, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 32'd0, 1, 0, 32'd0);
            idle(0);
            step(0, 1, 0, 32'd0, 1, 0, 32'd0);
            idle(1);
        end
        n_checks++; if (bus.switch_count !== 16'd3) begin n_fails++; $display("FAIL switch_count actual=%h required=3", bus.switch_count); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.controll = 1'b1; bus.write_process_pc = 1'b0; bus.new_pc_value = '0;
        bus.done_inst = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        @(negedge clk);
        test_reset();
        test_bios_count();
        test_launch();
        test_preempt();
        test_branch_wrap();
        test_reset_in_to_bios();
        test_random();
`ifdef PC_SEQ_SWITCH_COUNT_EN
        test_switch_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter BIOS_ENTRY, default 32'd0: address where the BIOS starts each time control returns to it.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port controll, input, 1 bit: 1 = BIOS owns the core, 0 = the process may run.
REQ-005 SHALL have port write_process_pc, input, 1 bit: load the process PC from new_pc_value.
REQ-006 SHALL have port new_pc_value, input, 32 bits: PC value used on a process PC load.
REQ-007 SHALL have port done_inst, input, 1 bit: the current instruction retires this cycle.
REQ-008 SHALL have port branch_taken, input, 1 bit: the retiring instruction redirects the PC.
REQ-009 SHALL have port branch_target, input, 32 bits: redirect address.
REQ-010 SHALL have port pc, output, 32 bits: the fetch address sent to instruction memory.
REQ-011 SHALL have port exec_mode, output, 1 bit: 0 = BIOS context, 1 = process context.
REQ-012 SHALL have port saved_pc, output, 32 bits: process PC captured at the last preemption.
REQ-013 SHALL have port switch_busy, output, 1 bit: high during a transition state.

Function
REQ-014 SHALL implement four states:
  - BIOS_RUN
  - TO_PROC
  - PROC_RUN
  - TO_BIOS
REQ-015 SHALL keep two internal 32-bit registers, bios_pc and process_pc; pc SHALL equal bios_pc in BIOS_RUN and TO_BIOS, and process_pc in TO_PROC and PROC_RUN.
REQ-016 In BIOS_RUN, when done_inst=1, bios_pc SHALL become branch_target if branch_taken=1, else bios_pc+1, with modulo-2^32 wrap (32'hFFFFFFFF+1 = 0).
REQ-017 In BIOS_RUN, done_inst=1 with controll=0 SHALL update bios_pc (REQ-016) and move to TO_PROC; controll=0 without done_inst SHALL NOT change state.
REQ-018 TO_PROC SHALL last exactly 1 cycle, then go to PROC_RUN; done_inst and branch inputs SHALL be ignored in TO_PROC.
REQ-019 In PROC_RUN, done_inst=1 SHALL advance process_pc by the same rule as REQ-016.
REQ-020 In PROC_RUN, done_inst=1 with controll=1 SHALL advance process_pc, then move to TO_BIOS; preemption SHALL occur only at an instruction boundary.
REQ-021 In TO_BIOS, for 1 cycle: saved_pc SHALL load process_pc, bios_pc SHALL load BIOS_ENTRY, then the state SHALL go to BIOS_RUN.
REQ-022 write_process_pc=1 SHALL load process_pc from new_pc_value only in BIOS_RUN.
REQ-023 If write_process_pc=1 and a BIOS_RUN->TO_PROC transition happen in the same cycle, the new value SHALL be the PC used in TO_PROC.
REQ-024 write_process_pc SHALL be ignored in all states other than BIOS_RUN.
REQ-025 exec_mode SHALL be 1 in TO_PROC and PROC_RUN, and 0 otherwise.
REQ-026 switch_busy SHALL be 1 in TO_PROC and TO_BIOS, and 0 otherwise.
REQ-027 All outputs SHALL be registered; pc SHALL reflect a state or PC update one cycle after the causing edge.

Reset
REQ-028 On rst=1 at posedge, the state SHALL go to BIOS_RUN, bios_pc to BIOS_ENTRY, and process_pc and saved_pc to 0.
REQ-029 On rst=1 at posedge, outputs SHALL take these values:
  - pc = BIOS_ENTRY
  - exec_mode = 0
  - switch_busy = 0
  - switch_count = 0
REQ-030 rst SHALL take priority over every other input, including rst during TO_PROC or TO_BIOS; no partial save SHALL survive.

Configuration
REQ-031 With macro PC_SEQ_SWITCH_COUNT_EN defined, the block SHALL add output switch_count, 16 bits, incremented on every entry to TO_BIOS and wrapping 16'hFFFF->0.
REQ-032 With PC_SEQ_SWITCH_COUNT_EN undefined, the switch_count port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 State encodings, the 32-bit PC width constant and the BIOS_ENTRY default SHALL reside in the shared processor package/include.
REQ-034 The next-PC computation (increment or branch select) SHALL be a sub-module named pc_next_calc, instantiated once for each context register.

Verification
REQ-035 After rst: pc=0; 3 pulses of done_inst with no branch -> pc=3, exec_mode=0.
REQ-036 In BIOS_RUN: write_process_pc with new_pc_value=0x40, then done_inst with controll=0 -> TO_PROC for 1 cycle with switch_busy=1, then pc=0x40, exec_mode=1.
REQ-037 In PROC_RUN at pc=0x45: controll=1 without done_inst -> state unchanged; controll=1 with done_inst -> saved_pc=0x46, then pc=BIOS_ENTRY, exec_mode=0.
REQ-038 In PROC_RUN: branch_taken=1, branch_target=0x100, done_inst=1 -> pc=0x100; at process_pc=0xFFFFFFFF, done_inst=1 -> pc=0.
REQ-039 rst asserted during TO_BIOS -> next cycle pc=0, saved_pc=0, exec_mode=0.
REQ-040 With PC_SEQ_SWITCH_COUNT_EN defined: 3 preemptions -> switch_count=3; starting from switch_count=16'hFFFF, 1 preemption -> switch_count=0.
